// File: rtl/uart_send.sv
// uart_send: UART transmitter, 8N1 frames, bit period of CLK_FREQ/UART_BPS sys_clk cycles.
// Define UART_TX_PARITY_EN to insert a parity bit (8E1/8O1 selected by PARITY_ODD).
module uart_send #(
    parameter int CLK_FREQ   = 65000000,
    parameter int UART_BPS   = 115200,
    parameter int PARITY_ODD = 0
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       tx_en,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       uart_txd
);

    localparam int          BPS_CNT  = CLK_FREQ / UART_BPS;
    localparam logic [15:0] BPS_LAST = 16'(BPS_CNT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    // PARITY_ODD is meaningful only when the parity bit is built in.
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_parity_odd_out_of_range
    end

`ifdef UART_TX_PARITY_EN
    localparam logic PAR_SENSE = (PARITY_ODD != 0);
`endif

    state_t      state_q, state_d;
    logic [15:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_q, txd_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        bit_end;

    assign bit_end = (clk_cnt_q == BPS_LAST);

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        ready_d   = ready_q;
        done_d    = 1'b0;

        if (state_q != ST_IDLE) begin
            clk_cnt_d = bit_end ? 16'd0 : clk_cnt_q + 16'd1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (tx_en && ready_q) begin
                    shift_d   = tx_data;
                    state_d   = ST_START;
                    txd_d     = 1'b0;
                    ready_d   = 1'b0;
                    clk_cnt_d = 16'd0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                    txd_d     = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        txd_d   = (^shift_q) ^ PAR_SENSE;
`else
                        state_d = ST_STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        txd_d     = shift_q[bit_idx_q + 3'd1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    txd_d   = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    state_d = ST_IDLE;
                    txd_d   = 1'b1;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_IDLE;
            clk_cnt_q <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            txd_q     <= 1'b1;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
        end
    end

    assign uart_txd = txd_q;
    assign tx_ready = ready_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_send.sv
// tb_uart_send: directed and random frames against a bit-level frame model.
// Build with UART_TX_PARITY_EN defined to exercise the parity frame.
module tb_uart_send;

    localparam int CLK_FREQ = 1000000;
    localparam int UART_BPS = 100000;
    localparam int BPS      = CLK_FREQ / UART_BPS;
    localparam int PODD     = 0;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       tx_en     = 1'b0;
    logic [7:0] tx_data   = 8'd0;
    logic       tx_ready;
    logic       tx_done;
    logic       uart_txd;

    int n_checks = 0;
    int n_fails  = 0;

    uart_send #(
        .CLK_FREQ  (CLK_FREQ),
        .UART_BPS  (UART_BPS),
        .PARITY_ODD(PODD)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .tx_en    (tx_en),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .tx_done  (tx_done),
        .uart_txd (uart_txd)
    );

    always #5 sys_clk = ~sys_clk;

    // Level of frame bit k: start, 8 data LSB first, optional parity, stop.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == NBITS - 1) return 1'b1;
        return 1'(($countones(b) + PODD) % 2);
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            check("idle_txd", 8'(uart_txd), 8'd1);
            check("idle_ready", 8'(tx_ready), 8'd1);
            check("idle_done", 8'(tx_done), 8'd0);
            @(negedge sys_clk);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
    task automatic accept(input logic [7:0] b);
        check("ready_pre", 8'(tx_ready), 8'd1);
        tx_en   = 1'b1;
        tx_data = b;
        @(negedge sys_clk);
    endtask

    // Sample point j is the negedge following the j-th edge after accept.
    task automatic expect_frame(input logic [7:0] b, input bit hold,
                                input logic [7:0] nxt, input bit poke);
        logic [7:0] dec;
        dec = 8'd0;
        for (int j = 0; j <= NBITS * BPS; j++) begin
            if (j < NBITS * BPS) begin
                check("frame_txd", 8'(uart_txd), 8'(frame_bit(b, j / BPS)));
                if (j / BPS >= 1 && j / BPS <= 8 && j % BPS == BPS / 2)
                    dec[j / BPS - 1] = uart_txd;
            end else begin
                check("stop_end_txd", 8'(uart_txd), 8'd1);
            end
            check("frame_done", 8'(tx_done), 8'(j == NBITS * BPS));
            check("frame_ready", 8'(tx_ready), 8'(j == NBITS * BPS));
            if (j < NBITS * BPS) begin
                tx_en   = hold || (poke && j == 37);
                tx_data = (poke && j == 37) ? 8'h00 : 8'($urandom);
            end else begin
                tx_en   = hold;
                tx_data = nxt;
            end
            @(negedge sys_clk);
        end
        check("decoded", dec, b);
    endtask

    initial begin
        logic [7:0] b, b2;

        repeat (3) @(negedge sys_clk);
        check("rst_txd", 8'(uart_txd), 8'd1);
        check("rst_ready", 8'(tx_ready), 8'd1);
        check("rst_done", 8'(tx_done), 8'd0);
        sys_rst_n = 1'b1;
        idle(50);

        accept(8'hA5);
        expect_frame(8'hA5, 1'b0, 8'h00, 1'b1);
        idle(30);

        accept(8'h55);
        expect_frame(8'h55, 1'b1, 8'h0F, 1'b0);
        expect_frame(8'h0F, 1'b0, 8'h00, 1'b0);
        idle(20);

`ifdef UART_TX_PARITY_EN
        accept(8'h07);
        expect_frame(8'h07, 1'b0, 8'h00, 1'b0);
        idle(3);
        accept(8'h03);
        expect_frame(8'h03, 1'b0, 8'h00, 1'b0);
        idle(3);
`endif

        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            accept(b);
            expect_frame(b, 1'b0, 8'h00, 1'b0);
            idle(1 + int'($urandom_range(0, 3)));
        end

        b  = 8'($urandom);
        b2 = 8'($urandom);
        accept(b);
        expect_frame(b, 1'b1, b2, 1'b0);
        expect_frame(b2, 1'b0, 8'h00, 1'b0);
        idle(5);

        // Reset in the middle of data bit 3, which is forced to 0.
        b = 8'($urandom) & 8'hF7;
        accept(b);
        tx_en = 1'b0;
        repeat (45) @(negedge sys_clk);
        check("bit3_txd", 8'(uart_txd), 8'd0);
        #1 sys_rst_n = 1'b0;
        #1;
        check("async_rst_txd", 8'(uart_txd), 8'd1);
        check("async_rst_ready", 8'(tx_ready), 8'd1);
        check("async_rst_done", 8'(tx_done), 8'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        idle(120);
        b = 8'($urandom);
        accept(b);
        expect_frame(b, 1'b0, 8'h00, 1'b0);
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
